// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// ----------------------------------------------------------------------------
// Reset sequencer and health monitor for the ip_pll clock generator. The
// block runs entirely on the board reference clock. It pulses the PLL reset,
// waits for the PLL to settle, and then judges both PLL outputs by counting
// heartbeat toggles that the clk0/clk1 domains produce. The PLL wrapper has no
// lock pin, so this count is the only evidence that the PLL is running.
// Downstream clock-domain logic is held in reset until a measurement window
// passes. A failed attempt is retried a bounded number of times. After that
// the block halts with a fault flag until software issues reinit_req.
//
// Ports
//   refclk        in   reference clock; all logic runs in this domain
//   rst_n         in   asynchronous active-low reset
//   beat0         in   heartbeat toggle from the clk0 domain (asynchronous)
//   beat1         in   heartbeat toggle from the clk1 domain (asynchronous)
//   reinit_req    in   single-cycle request to restart and clear retries
//   pll_rst       out  active-high reset to the PLL
//   domain_rst_n  out  active-low reset for clk0/clk1 domain logic
//   pll_ok        out  high while the PLL is judged healthy (RUN)
//   fault         out  high while halted after exhausting retries
//   retry_cnt     out  failed attempts since reset/reinit
//   state         out  current FSM state encoding, for debug
// ----------------------------------------------------------------------------
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 240,
    parameter int SETTLE_CYCLES = 24000,
    parameter int WIN_CYCLES    = 2400,
    parameter int BEAT0_MIN     = 16,
    parameter int BEAT0_MAX     = 24,
    parameter int BEAT1_MIN     = 4,
    parameter int BEAT1_MAX     = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               beat0,
    input  logic                               beat1,
    input  logic                               reinit_req,
    output logic                               pll_rst,
    output logic                               domain_rst_n,
    output logic                               pll_ok,
    output logic                               fault,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [2:0]                         state
);

    localparam int TMAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int TMAX   = (TMAX_A > WIN_CYCLES) ? TMAX_A : WIN_CYCLES;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RW     = $clog2(MAX_RETRY + 1);
    // Beat counters get one code above MAX, so the saturated value always
    // reads as out of range.
    localparam int C0W    = $clog2(BEAT0_MAX + 2);
    localparam int C1W    = $clog2(BEAT1_MAX + 2);

    localparam logic [TW-1:0]  RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]  SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]  WIN_LAST    = TW'(WIN_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_LIM   = RW'(MAX_RETRY);
    localparam logic [C0W-1:0] B0_MIN      = C0W'(BEAT0_MIN);
    localparam logic [C0W-1:0] B0_MAX      = C0W'(BEAT0_MAX);
    localparam logic [C1W-1:0] B1_MIN      = C1W'(BEAT1_MIN);
    localparam logic [C1W-1:0] B1_MAX      = C1W'(BEAT1_MAX);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_SETTLE    = 3'd1,
        S_CHECK     = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [C0W-1:0] cnt0_q, cnt0_d, cnt0_inc;
    logic [C1W-1:0] cnt1_q, cnt1_d, cnt1_inc;
    logic           miss_q, miss_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           pll_rst_q, dom_rst_n_q, pll_ok_q, fault_q;
    logic [1:0]     b0_sync_q, b1_sync_q;
    logic           b0_hist_q, b1_hist_q;
    logic           tog0, tog1, win_good;

    // 2-FF synchronisers plus one history flop. Each edge of the heartbeat
    // shows up as exactly one toggle pulse.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            b0_sync_q <= '0;
            b1_sync_q <= '0;
            b0_hist_q <= 1'b0;
            b1_hist_q <= 1'b0;
        end else begin
            b0_sync_q <= {b0_sync_q[0], beat0};
            b1_sync_q <= {b1_sync_q[0], beat1};
            b0_hist_q <= b0_sync_q[1];
            b1_hist_q <= b1_sync_q[1];
        end
    end

    assign tog0 = b0_sync_q[1] ^ b0_hist_q;
    assign tog1 = b1_sync_q[1] ^ b1_hist_q;

    // Saturating counts including this cycle's toggle. The last window cycle
    // judges these values, so a toggle on that cycle still counts.
    assign cnt0_inc = (tog0 && (cnt0_q != '1)) ? cnt0_q + C0W'(1) : cnt0_q;
    assign cnt1_inc = (tog1 && (cnt1_q != '1)) ? cnt1_q + C1W'(1) : cnt1_q;
    assign win_good = (cnt0_inc >= B0_MIN) && (cnt0_inc <= B0_MAX) &&
                      (cnt1_inc >= B1_MIN) && (cnt1_inc <= B1_MAX);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        cnt0_d  = '0;
        cnt1_d  = '0;
        miss_d  = miss_q;
        retry_d = retry_q;
        case (state_q)
            S_RESET_PLL: begin
                miss_d = 1'b0;
                if (timer_q == RST_LAST) begin
                    state_d = S_SETTLE;
                    timer_d = '0;
                end
            end
            S_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    timer_d = '0;
                end
            end
            S_CHECK, S_RUN: begin
                cnt0_d = cnt0_inc;
                cnt1_d = cnt1_inc;
                if (timer_q == WIN_LAST) begin
                    timer_d = '0;
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                    if (state_q == S_CHECK) begin
                        if (win_good) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_FAULT;
                            retry_d = retry_q + RW'(1);
                        end
                    end else if (win_good) begin
                        miss_d = 1'b0;
                    end else if (miss_q) begin
                        // Second bad window in a row.
                        state_d = S_FAULT;
                        retry_d = retry_q + RW'(1);
                        miss_d  = 1'b0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                // retry_q already holds the incremented count here.
                timer_d = '0;
                miss_d  = 1'b0;
                state_d = (retry_q < RETRY_LIM) ? S_RESET_PLL : S_HALT;
            end
            S_HALT: begin
                timer_d = '0;
            end
            default: begin
                state_d = S_RESET_PLL;
                timer_d = '0;
                miss_d  = 1'b0;
            end
        endcase
        if (reinit_req) begin
            state_d = S_RESET_PLL;
            timer_d = '0;
            cnt0_d  = '0;
            cnt1_d  = '0;
            miss_d  = 1'b0;
            retry_d = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            miss_q      <= 1'b0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_n_q <= 1'b0;
            pll_ok_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            miss_q      <= miss_d;
            retry_q     <= retry_d;
            // Outputs are decoded from the next state. They change in the
            // same update as the state, so domain_rst_n drops together with
            // any exit from RUN.
            pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_HALT);
            dom_rst_n_q <= (state_d == S_RUN);
            pll_ok_q    <= (state_d == S_RUN);
            fault_q     <= (state_d == S_HALT);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_rst_n_q;
    assign pll_ok       = pll_ok_q;
    assign fault        = fault_q;
    assign retry_cnt    = retry_q;
    assign state        = state_q;

endmodule
